// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite master: turns one valid/ready command into one
// SINGLE transfer and returns read data / error status on a valid/ready response.
module ahb_lite_cmd_master #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Size must fit the bus and the address must be naturally aligned to it.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [2:0] addr_lsb);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr_lsb[0] == 1'b0);
            3'd2:    ok = (addr_lsb[1:0] == 2'b00);
            3'd3:    ok = (DATA_WIDTH == 64) && (addr_lsb == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e                  state_q,     state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    busy_q,      busy_d;
    logic [ADDR_WIDTH-1:0]   haddr_q,     haddr_d;
    logic [1:0]              htrans_q,    htrans_d;
    logic                    hwrite_q,    hwrite_d;
    logic [2:0]              hsize_q,     hsize_d;
    logic [DATA_WIDTH-1:0]   hwdata_q,    hwdata_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (cmd_legal(cmd_size, cmd_addr[2:0])) begin
                        state_d  = ST_ADDR;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                        htrans_d = TRANS_NONSEQ;
                        wdata_d  = cmd_wdata;
                    end else begin
                        // Rejected command never reaches the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = TRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end else begin
                        hwdata_d = hwdata_q;
                    end
                end else begin
                    htrans_d = TRANS_NONSEQ;
                end
            end
            ST_DATA: begin
                // First ERROR cycle has HREADY low and is simply another wait.
                if (HREADY) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    if (!hwrite_q && !HRESP) begin
                        rsp_rdata_d = HRDATA;
                    end else begin
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                htrans_d    = TRANS_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            haddr_q     <= {ADDR_WIDTH{1'b0}};
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hwdata_q    <= {DATA_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;

endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
- Single-outstanding AHB-Lite bus master. Converts a valid/ready command interface into AHB-Lite single transfers.
- Returns read data and error status on a valid/ready response interface.
- It is the initiator end of the AHB-Lite protocol that sram_controller responds to. It replaces the file-reading bus master when on-chip logic (DMA, debug bridge, self-test) must drive the SRAM controller or any other AHB-Lite slave.

Parameters:
- ADDR_WIDTH, 32, width of HADDR and cmd_addr.
- DATA_WIDTH, 32, width of HWDATA/HRDATA/cmd_wdata/rsp_rdata; must be 32 or 64.
- HPROT_VAL, 4'b0011, constant driven on HPROT (data access, privileged).

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_size  in  3  AHB HSIZE encoding (0=byte, 1=half, 2=word, 3=dword).
- cmd_wdata  in  DATA_WIDTH  write data, already lane-aligned by the requester.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester consumes response.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_err  out  1  1=slave ERROR or rejected command.
- busy  out  1  high whenever state != IDLE.
- HADDR  out  ADDR_WIDTH; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HWDATA  out  DATA_WIDTH.
- HRDATA  in  DATA_WIDTH; HREADY  in  1; HRESP  in  1 (0=OKAY, 1=ERROR).

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; busy=0.
  - HTRANS=2'b00 (IDLE); HADDR=0; HWRITE=0; HSIZE=0; HWDATA=0.
  - HBURST is constant 3'b000 (SINGLE). HPROT is constant HPROT_VAL.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, the command is checked and captured.
  - Illegal command if either condition holds:
    - cmd_size > log2(DATA_WIDTH/8).
    - cmd_addr not aligned to 2^cmd_size bytes.
  - Illegal command: go to RESP with rsp_err=1 and rsp_rdata=0. No bus activity (HTRANS stays IDLE).
  - Legal command: go to ADDR. On that same edge, register HADDR/HWRITE/HSIZE from the command and set HTRANS=NONSEQ (2'b10). Latch wdata internally.
- ADDR:
  - HTRANS=NONSEQ, held stable while HREADY=0.
  - Edge with HREADY=1 completes the address phase. Go to DATA, set HTRANS=IDLE, drive HWDATA=latched wdata (writes only; HWDATA unchanged for reads).
- DATA:
  - HTRANS=IDLE; HWDATA held stable.
  - HREADY=0: wait, with no limit on wait states.
  - Edge with HREADY=1: capture rsp_err=HRESP and rsp_rdata=(read && !HRESP) ? HRDATA : 0. Go to RESP with rsp_valid=1.
  - Two-cycle ERROR: the first cycle (HRESP=1, HREADY=0) is treated as a wait. The error is taken on the HREADY=1 cycle. No transfer needs cancelling because HTRANS is already IDLE.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE.
  - cmd_ready is 0 in RESP. A new command is accepted no earlier than the cycle after the response handshake.
- Latency, zero-wait legal transfer:
  - Command accepted at edge N.
  - NONSEQ on bus during cycle N..N+1.
  - Data phase N+1..N+2.
  - rsp_valid=1 after edge N+2.
  - Minimum throughput: one transfer per 4 cycles with rsp_ready held high.
- cmd_* inputs are ignored outside IDLE; the command is captured only on the accept edge.
- Reset mid-operation: synchronous reset wins over every transition. Next edge goes to IDLE with all reset values; any captured command or response is discarded.
- HRESP=1 with HREADY=1 in a single cycle (non-compliant slave) is still reported as rsp_err=1.

Test Plan:
- Word write, zero-wait: cmd addr=0x0000_0010, size=2, wdata=0xDEADBEEF, write=1 -> response checked:
  - HTRANS=NONSEQ one cycle with HADDR=0x10, HWRITE=1, HSIZE=2.
  - Next cycle HWDATA=0xDEADBEEF.
  - rsp_valid 3 cycles after accept, rsp_err=0.
- Read with 3 wait states: cmd addr=0x10 read, slave holds HREADY=0 for 3 data-phase cycles, HRDATA=0xDEADBEEF -> checks:
  - rsp_rdata=0xDEADBEEF, rsp_valid after exactly 6 cycles.
  - HWDATA unchanged throughout.
- ERROR response: slave returns HRESP=1,HREADY=0 then HRESP=1,HREADY=1 on read of 0x4000_0000 -> rsp_err=1, rsp_rdata=0, block returns to IDLE.
- Misaligned/oversize: cmd addr=0x13 size=1, then size=3 with DATA_WIDTH=32 -> rsp_err=1 within 1 cycle each, HTRANS never leaves IDLE.
- Backpressure: rsp_ready=0 for 5 cycles after byte read of 0x11 (HRDATA=0x0000AB00) -> checks:
  - rsp_rdata=0x0000AB00 stable and cmd_ready=0 for all 5 cycles.
  - Accepted on rsp_ready=1; cmd_ready=1 the next cycle.
- Reset in DATA state of a write -> next edge HTRANS=IDLE, rsp_valid=0, cmd_ready=1, HWDATA=0, no response ever issued for the aborted command.
